bcd_stopwatch_ctrl: RTL and testbench

//  Run/pause/clear controller for a cascade of N_DIGITS BCD decade counters.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_stopwatch_ctrl_if.sv | 23 ++
 rtl/bcd_digit.sv | 27 ++
 rtl/bcd_stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its decade cells.
package bcd_pkg;

    // Width of one BCD digit and the largest legal digit code.
    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // Run/pause/clear controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Next code of a decade cell. Anything at or above 9 folds back to 0,
    // so a corrupted code can never get stuck outside 0..9.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q);
        return (q >= BCD_MAX) ? '0 : q + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control pulses and display outputs of the BCD stopwatch controller.
// master = the block issuing pulses and reading the display value,
// slave  = the stopwatch controller itself.
interface bcd_stopwatch_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                  start_stop;
    logic                  clear;
    logic                  lap;
    logic [4*N_DIGITS-1:0] digits_o;
    logic                  running;
    logic                  overflow;

    modport master (
        output start_stop, clear, lap,
        input  digits_o, running, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output digits_o, running, overflow
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade cell: synchronous clear, increment-with-wrap, at_max flag
// used to build the carry chain to the next more significant digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             CLK,
    input  logic             Rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    // Digit register: clear has priority over increment.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= bcd_next(q);
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for a cascade of N_DIGITS BCD decade counters.
// A prescaler divides CLK by TICK_DIV into a count tick; each digit is
// enabled by the tick ANDed with the at_max flags of all lower digits.
// Optional feature macro: LAP_HOLD_EN (lap snapshot of the displayed value).
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                CLK,
    input  logic                Rst,
    bcd_stopwatch_ctrl_if.slave sw
);

    localparam int             PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);

    state_t                      state;
    logic   [PW-1:0]             presc;
    logic                        running_q;
    logic                        overflow_q;
    logic                        tick;
    logic                        clr_acc;
    logic   [N_DIGITS:0]         carry;
    logic   [N_DIGITS-1:0]       at_max;
    logic   [BCD_W*N_DIGITS-1:0] count;

    // A tick fires on the last prescaler phase while running.
    assign tick    = (state == RUN) && (presc == P_LAST);
    // Clear is only honoured outside RUN.
    assign clr_acc = sw.clear && (state != RUN);

    assign carry[0] = tick;

    genvar k;
    generate
        for (k = 0; k < N_DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .CLK    (CLK),
                .Rst    (Rst),
                .clr    (clr_acc),
                .inc    (carry[k]),
                .q      (count[BCD_W*k +: BCD_W]),
                .at_max (at_max[k])
            );
            assign carry[k+1] = carry[k] & at_max[k];
        end
    endgenerate

    // Controller FSM with prescaler, registered running flag and sticky overflow.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            presc      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // carry[N_DIGITS] is a tick seen with every digit at 9: the wrap.
            if (clr_acc) begin
                overflow_q <= 1'b0;
            end else if (carry[N_DIGITS]) begin
                overflow_q <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    presc <= '0;
                    if (!sw.clear && sw.start_stop) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (sw.start_stop) begin
                        state     <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    // Prescaler holds so a resume keeps the tick phase.
                    if (sw.clear) begin
                        state <= IDLE;
                        presc <= '0;
                    end else if (sw.start_stop) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    presc     <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign sw.running  = running_q;
    assign sw.overflow = overflow_q;

`ifdef LAP_HOLD_EN
    logic                        hold_active;
    logic [BCD_W*N_DIGITS-1:0]   hold_q;

    // Lap hold: toggle on lap in RUN; any exit from RUN or accepted clear releases it.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            hold_active <= 1'b0;
            hold_q      <= '0;
        end else if (((state == RUN) && sw.start_stop) || clr_acc) begin
            hold_active <= 1'b0;
        end else if ((state == RUN) && sw.lap) begin
            if (hold_active) begin
                hold_active <= 1'b0;
            end else begin
                hold_active <= 1'b1;
                hold_q      <= count;
            end
        end
    end

    assign sw.digits_o = hold_active ? hold_q : count;
`else
    logic unused_lap;
    assign unused_lap  = sw.lap;
    assign sw.digits_o = count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with N_DIGITS=2, TICK_DIV=2.
// Expected values are hand-computed: with TICK_DIV=2 the count advances on
// every second edge after the edge that enters RUN.
module tb_bcd_stopwatch_ctrl;

    localparam int N_DIGITS = 2;
    localparam int TICK_DIV = 2;
`ifdef LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Rst;

    always #5 CLK = ~CLK;

    bcd_stopwatch_ctrl_if #(.N_DIGITS(N_DIGITS)) sw ();

    bcd_stopwatch_ctrl #(
        .N_DIGITS (N_DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLK (CLK),
        .Rst (Rst),
        .sw  (sw)
    );

    typedef struct {
        string      name;
        logic       ss;
        logic       cl;
        logic       lp;
        int         ncyc;
        logic [7:0] exp_d;
        logic       exp_run;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input string nm, input logic ss, input logic cl,
                                input logic lp, input int n, input logic [7:0] d,
                                input logic r, input logic o);
        vec_t v;
        v.name = nm; v.ss = ss; v.cl = cl; v.lp = lp; v.ncyc = n;
        v.exp_d = d; v.exp_run = r; v.exp_ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] ed,
                         input logic er, input logic eo);
        checks++;
        if (sw.digits_o !== ed || sw.running !== er || sw.overflow !== eo) begin
            errors++;
            $display("FAIL %s: got digits=%h running=%b overflow=%b, want digits=%h running=%b overflow=%b",
                     name, sw.digits_o, sw.running, sw.overflow, ed, er, eo);
        end
    endtask

    // Drive one-cycle pulses on the first edge, then idle; n edges in total.
    task automatic step(input logic ss, input logic cl, input logic lp, input int n);
        sw.start_stop = ss;
        sw.clear      = cl;
        sw.lap        = lp;
        @(posedge CLK);
        #1;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        for (int i = 1; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        vecs.push_back(mk("idle_after_rst", 0, 0, 0,   1, 8'h00, 0, 0));
        vecs.push_back(mk("start",          1, 0, 0,   1, 8'h00, 1, 0));
        vecs.push_back(mk("prescale_half",  0, 0, 0,   1, 8'h00, 1, 0));
        vecs.push_back(mk("first_tick",     0, 0, 0,   1, 8'h01, 1, 0));
        vecs.push_back(mk("run_20",         0, 0, 0,  18, 8'h10, 1, 0));
        vecs.push_back(mk("run_to_12",      0, 0, 0,   4, 8'h12, 1, 0));
        vecs.push_back(mk("clear_in_run",   0, 1, 0,   1, 8'h12, 1, 0));
        vecs.push_back(mk("after_clr_run",  0, 0, 0,   1, 8'h13, 1, 0));
        vecs.push_back(mk("pause",          1, 0, 0,   1, 8'h13, 0, 0));
        vecs.push_back(mk("paused_10",      0, 0, 0,  10, 8'h13, 0, 0));
        vecs.push_back(mk("resume",         1, 0, 0,   1, 8'h13, 1, 0));
        vecs.push_back(mk("phase_kept",     0, 0, 0,   1, 8'h14, 1, 0));
        vecs.push_back(mk("pause2",         1, 0, 0,   1, 8'h14, 0, 0));
        vecs.push_back(mk("clear_and_ss",   1, 1, 0,   1, 8'h00, 0, 0));
        vecs.push_back(mk("idle_hold",      0, 0, 0,   3, 8'h00, 0, 0));
        vecs.push_back(mk("start2",         1, 0, 0,   1, 8'h00, 1, 0));
        vecs.push_back(mk("run_to_99",      0, 0, 0, 198, 8'h99, 1, 0));
        vecs.push_back(mk("wrap",           0, 0, 0,   2, 8'h00, 1, 1));
        vecs.push_back(mk("after_wrap",     0, 0, 0,   2, 8'h01, 1, 1));
        vecs.push_back(mk("clear_run_ovf",  0, 1, 0,   1, 8'h01, 1, 1));
        vecs.push_back(mk("pause_ovf",      1, 0, 0,   1, 8'h02, 0, 1));
        vecs.push_back(mk("clear_ovf",      0, 1, 0,   1, 8'h00, 0, 0));
        vecs.push_back(mk("clear_idle",     0, 1, 0,   1, 8'h00, 0, 0));

        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        Rst           = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 8'h00, 0, 0);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].ss, vecs[i].cl, vecs[i].lp, vecs[i].ncyc);
            check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_run, vecs[i].exp_ovf);
        end

        // Lap sequence: capture on a non-tick edge, hold while the count advances.
        step(1, 0, 0, 1); check("lap_start",   8'h00, 1, 0);
        step(0, 0, 0, 6); check("lap_pre",     8'h03, 1, 0);
        step(0, 0, 1, 1); check("lap_capture", 8'h03, 1, 0);
        step(0, 0, 0, 7); check("lap_held",    LAP_EN ? 8'h03 : 8'h07, 1, 0);
        step(0, 0, 1, 1); check("lap_release", 8'h07, 1, 0);
        step(0, 0, 0, 1); check("live_again",  8'h08, 1, 0);
        step(0, 0, 1, 1); check("lap2",        8'h08, 1, 0);
        step(1, 0, 0, 1); check("leave_run",   8'h09, 0, 0);
        step(0, 0, 1, 1); check("lap_pause",   8'h09, 0, 0);

        // Asynchronous reset in the middle of a running count.
        step(0, 1, 0, 1);  check("pre_rst_clear", 8'h00, 0, 0);
        step(1, 0, 0, 1);  check("pre_rst_start", 8'h00, 1, 0);
        step(0, 0, 0, 74); check("run_to_37",     8'h37, 1, 0);
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst", 8'h00, 0, 0);
        @(posedge CLK);
        #1;
        Rst = 1'b0;
        step(0, 0, 0, 5);  check("idle_after_async", 8'h00, 0, 0);
        step(1, 0, 0, 1);  check("restart",          8'h00, 1, 0);
        step(0, 0, 0, 2);  check("restart_tick",     8'h01, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
